camera_poweroff_sequence_sm: RTL and testbench
==============================================

# camera_poweroff_sequence_sm

Camera power-down sequencer: the reverse-direction partner of the camera power-on sequencer. It sits between the power-on sequencer outputs and the camera power pins. While idle it passes the enables through on a registered path. On request it removes them in the reverse of the power-up order, XCLR → INCK_EN → 3V3 → 1V8 → 1V2, with a programmable dwell between steps, then reports completion.

## Interface
Parameters:
- STEP_DELAY, 32'd1000000: dwell per step, in ctrl_clk_i cycles; a value of 0 behaves as 1.

Ports:
- ctrl_clk_i  in  1  control clock; the only clock
- ctrl_rst_i  in  1  reset; synchronous, active-high
- pwrdn_req_i  in  1  power-down request, level; sampled every cycle
- reg_1v2_en_i / reg_1v8_en_i / reg_3v3_en_i  in  1 each  rail enables from the power-on sequencer
- inck_en_i / xclr_i  in  1 each  INCK enable and XCLR from the power-on sequencer
- reg_1v2_en_o / reg_1v8_en_o / reg_3v3_en_o  out  1 each  gated rail enables to pins
- inck_en_o / xclr_o  out  1 each  gated INCK enable and XCLR to pins
- busy_o  out  1  power-down sequence in progress
- pwrdn_done_o  out  1  all five signals forced low; sequence complete
- state_o  out  3  encoded FSM state; present only with CAM_PWROFF_STATUS_EN

## Operation
- FSM states, in order: IDLE, XCLR_OFF, INCK_OFF, V33_OFF, V18_OFF, V12_OFF, DONE.
- IDLE:
  - gate mask is all ones, so each output follows its input through one register;
  - pwrdn_req_i = 1 moves the FSM to XCLR_OFF.
- Each *_OFF state:
  - clears its own gate bit; bits cleared by earlier states stay cleared;
  - lasts exactly STEP_DELAY cycles, then advances to the next state;
  - V12_OFF advances to DONE.
- DONE:
  - all gate bits stay cleared;
  - the FSM stays in DONE while pwrdn_req_i = 1;
  - pwrdn_req_i = 0 returns it to IDLE, which restores the mask and re-enables pass-through.
- pwrdn_req_i dropping during any *_OFF state is ignored; a started sequence always runs to completion.
- Output formula: out <= in & mask(state). Any input that is already low gives a low output regardless of the mask.
- Step counter:
  - 32-bit, cleared on entry to each *_OFF state;
  - increments every cycle in *_OFF states; the step ends at count == max(STEP_DELAY,1) − 1;
  - it cannot wrap, because it is always cleared before it reaches the terminal count.
- busy_o is registered and equals "state is any *_OFF".
- pwrdn_done_o is registered and equals "state is DONE".

## Timing
- Reset values: every output 0; state IDLE; counter 0; mask all ones.
- After reset releases, outputs track their inputs with 1-cycle latency.
- pwrdn_req_i sampled high at edge N (D = effective STEP_DELAY):
  - state = XCLR_OFF at edge N+1; busy_o = 1 at N+2;
  - xclr_o = 0 at N+2;
  - inck_en_o = 0 at N+2+D;
  - reg_3v3_en_o = 0 at N+2+2D;
  - reg_1v8_en_o = 0 at N+2+3D;
  - reg_1v2_en_o = 0 at N+2+4D;
  - pwrdn_done_o = 1 and busy_o = 0 at N+2+5D.
- pwrdn_req_i sampled low in DONE at edge M: pwrdn_done_o = 0 and outputs follow inputs again from edge M+2.
- A request held high across a DONE→IDLE transition cannot occur, because DONE exits only on request low.
- ctrl_rst_i asserted mid-sequence: at the next edge every output goes to 0 and the FSM goes to IDLE. Pass-through resumes after reset releases.

## Configuration
- CAM_PWROFF_STATUS_EN defined:
  - adds the state_o port;
  - encoding: IDLE=0, XCLR_OFF=1, INCK_OFF=2, V33_OFF=3, V18_OFF=4, V12_OFF=5, DONE=6;
  - registered alongside busy_o; reset value 0.
- CAM_PWROFF_STATUS_EN undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Shared package cam_pwr_pkg holds:
  - the state encoding constants;
  - the gate-bit index constants: XCLR=0, INCK=1, V33=2, V18=3, V12=4;
  - the default dwell constant, which the power-on sequencer also uses.
- One sub-module, cam_pwr_step_timer: clear and enable inputs, a terminal-count output, and a STEP_DELAY parameter. It is reusable by a future rewrite of the power-on sequencer.

## Test plan
- Reset, then all inputs = 1 with no request: outputs = 1 from 1 cycle after the inputs are applied; busy_o = 0 and pwrdn_done_o = 0.
- STEP_DELAY=4, request at edge 0:
  - xclr_o falls at edge 2, inck_en_o at 6, reg_3v3_en_o at 10, reg_1v8_en_o at 14, reg_1v2_en_o at 18;
  - pwrdn_done_o rises at 22;
  - busy_o is high for edges 2–21.
- Same run, request dropped at edge 8: the sequence continues and pwrdn_done_o still rises at 22. The FSM then returns to IDLE and outputs follow the inputs at edge 24.
- STEP_DELAY=0: behaves as D=1; the five outputs fall on consecutive edges 2–6 and pwrdn_done_o rises at edge 7.
- ctrl_rst_i pulsed at edge 12 of the STEP_DELAY=4 run: all outputs are 0 at edge 13 and the state is IDLE. After release with no request, outputs return to 1.
- CAM_PWROFF_STATUS_EN build: state_o steps through 0,1,2,3,4,5,6 in step with the transitions above.

Source files
------------

// File: rtl/camera_poweroff_sequence_sm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cam_pwr_pkg (package)
//  Purpose  : Shared definitions for the camera power sequencers: FSM state
//             encoding, gate-bit indices, default dwell and the gate-mask
//             helper used by the power-down sequencer.
//  Macros   : none
//  Revision : 1.0 - initial release
// ============================================================================
package cam_pwr_pkg;

  // Default dwell per sequencing step, in control-clock cycles. The power-on
  // sequencer uses the same value so both directions have matching pacing.
  localparam logic [31:0] c_STEP_DELAY_DEFAULT = 32'd1000000;

  // Gate-bit positions within the 5-bit enable vector.
  localparam int unsigned c_GATE_XCLR = 0;
  localparam int unsigned c_GATE_INCK = 1;
  localparam int unsigned c_GATE_V33  = 2;
  localparam int unsigned c_GATE_V18  = 3;
  localparam int unsigned c_GATE_V12  = 4;
  localparam int unsigned c_GATE_W    = 5;

  // State encoding; also the value reported on state_o.
  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_XCLR_OFF = 3'd1;
  localparam logic [2:0] c_ST_INCK_OFF = 3'd2;
  localparam logic [2:0] c_ST_V33_OFF  = 3'd3;
  localparam logic [2:0] c_ST_V18_OFF  = 3'd4;
  localparam logic [2:0] c_ST_V12_OFF  = 3'd5;
  localparam logic [2:0] c_ST_DONE     = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE     = c_ST_IDLE,
    ST_XCLR_OFF = c_ST_XCLR_OFF,
    ST_INCK_OFF = c_ST_INCK_OFF,
    ST_V33_OFF  = c_ST_V33_OFF,
    ST_V18_OFF  = c_ST_V18_OFF,
    ST_V12_OFF  = c_ST_V12_OFF,
    ST_DONE     = c_ST_DONE
  } pwroff_state_t;

  // Gate mask for a state. Bit order is {V12, V18, V33, INCK, XCLR}; each
  // *_OFF state clears its own bit on top of those already cleared.
  function automatic logic [c_GATE_W-1:0] pwroff_mask(input pwroff_state_t st);
    logic [c_GATE_W-1:0] m;
    m = '0;
    case (st)
      ST_IDLE:     m = 5'b11111;
      ST_XCLR_OFF: m = 5'b11110;
      ST_INCK_OFF: m = 5'b11100;
      ST_V33_OFF:  m = 5'b11000;
      ST_V18_OFF:  m = 5'b10000;
      ST_V12_OFF:  m = 5'b00000;
      ST_DONE:     m = 5'b00000;
      default:     m = 5'b00000;
    endcase
    return m;
  endfunction

  // True for the timed removal steps (XCLR_OFF .. V12_OFF).
  function automatic logic is_step_state(input pwroff_state_t st);
    return (st == ST_XCLR_OFF) || (st == ST_INCK_OFF) || (st == ST_V33_OFF) ||
           (st == ST_V18_OFF)  || (st == ST_V12_OFF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/camera_poweroff_sequence_sm_if.sv
`default_nettype none
// ============================================================================
//  Module   : camera_poweroff_sequence_sm_if (interface)
//  Purpose  : Bundles the power-down request, the five enables coming from
//             the power-on sequencer, the gated enables to the camera pins
//             and the status outputs.
//  Modports : slave  - the sequencer (consumes *_i, drives *_o)
//             master - the controlling side (drives *_i, observes *_o)
//  Macros   : CAM_PWROFF_STATUS_EN adds state_o (3-bit encoded FSM state)
//  Revision : 1.0 - initial release
// ============================================================================
interface camera_poweroff_sequence_sm_if;

  logic       pwrdn_req_i;
  logic       reg_1v2_en_i;
  logic       reg_1v8_en_i;
  logic       reg_3v3_en_i;
  logic       inck_en_i;
  logic       xclr_i;

  logic       reg_1v2_en_o;
  logic       reg_1v8_en_o;
  logic       reg_3v3_en_o;
  logic       inck_en_o;
  logic       xclr_o;
  logic       busy_o;
  logic       pwrdn_done_o;
`ifdef CAM_PWROFF_STATUS_EN
  logic [2:0] state_o;
`endif

  modport slave (
    input  pwrdn_req_i, reg_1v2_en_i, reg_1v8_en_i, reg_3v3_en_i, inck_en_i, xclr_i,
    output reg_1v2_en_o, reg_1v8_en_o, reg_3v3_en_o, inck_en_o, xclr_o,
    output busy_o, pwrdn_done_o
`ifdef CAM_PWROFF_STATUS_EN
    , output state_o
`endif
  );

  modport master (
    output pwrdn_req_i, reg_1v2_en_i, reg_1v8_en_i, reg_3v3_en_i, inck_en_i, xclr_i,
    input  reg_1v2_en_o, reg_1v8_en_o, reg_3v3_en_o, inck_en_o, xclr_o,
    input  busy_o, pwrdn_done_o
`ifdef CAM_PWROFF_STATUS_EN
    , input state_o
`endif
  );

endinterface
`default_nettype wire

// File: rtl/camera_poweroff_sequence_sm_step_timer.sv
`default_nettype none
// ============================================================================
//  Module   : cam_pwr_step_timer
//  Purpose  : Dwell timer for power sequencing steps. Counts enabled cycles
//             and flags the last cycle of a step of max(STEP_DELAY,1) cycles.
//  Ports    : ctrl_clk_i  - control clock
//             ctrl_rst_i  - synchronous active-high reset
//             clr_i       - clear count to 0 (wins over en_i)
//             en_i        - count this cycle
//             tc_o        - terminal count: enabled and on the last cycle
//  Params   : STEP_DELAY  - dwell length in cycles; 0 behaves as 1
//  Macros   : none
//  Revision : 1.0 - initial release
// ============================================================================
module cam_pwr_step_timer
  import cam_pwr_pkg::*;
#(
  parameter logic [31:0] STEP_DELAY = c_STEP_DELAY_DEFAULT
) (
  input  wire ctrl_clk_i,
  input  wire ctrl_rst_i,
  input  wire clr_i,
  input  wire en_i,
  output wire tc_o
);

  localparam logic [31:0] c_LAST_COUNT = (STEP_DELAY == 32'd0) ? 32'd0 : (STEP_DELAY - 32'd1);

  logic [31:0] r_count;

  // The owner clears the count on the terminal cycle, so it never reaches
  // past c_LAST_COUNT and cannot wrap.
  always_ff @(posedge ctrl_clk_i) begin
    if (ctrl_rst_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (en_i) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign tc_o = en_i && (r_count == c_LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/camera_poweroff_sequence_sm.sv
`default_nettype none
// ============================================================================
//  Module   : camera_poweroff_sequence_sm
//  Purpose  : Camera power-down sequencer. Passes the power-on sequencer's
//             enables to the pins through one register while idle; on
//             request removes them in the order XCLR, INCK_EN, 3V3, 1V8,
//             1V2 with STEP_DELAY cycles between steps, then reports done.
//  Ports    : ctrl_clk_i - control clock (only clock)
//             ctrl_rst_i - synchronous active-high reset
//             bus        - camera_poweroff_sequence_sm_if.slave: request,
//                          five input enables, five gated outputs, busy_o,
//                          pwrdn_done_o, optional state_o
//  Params   : STEP_DELAY - dwell per step in cycles (0 behaves as 1)
//  Macros   : CAM_PWROFF_STATUS_EN - adds the registered state_o output
//  Revision : 1.0 - initial release
// ============================================================================
module camera_poweroff_sequence_sm
  import cam_pwr_pkg::*;
#(
  parameter logic [31:0] STEP_DELAY = c_STEP_DELAY_DEFAULT
) (
  input wire ctrl_clk_i,
  input wire ctrl_rst_i,
  camera_poweroff_sequence_sm_if.slave bus
);

  pwroff_state_t         r_state;
  logic                  r_req;
  logic [c_GATE_W-1:0]   r_out;
  logic                  r_busy;
  logic                  r_done;
`ifdef CAM_PWROFF_STATUS_EN
  logic [2:0]            r_state_o;
`endif

  logic [c_GATE_W-1:0]   w_in;
  logic                  w_in_step;
  logic                  w_step_clr;
  logic                  w_step_tc;

  assign w_in[c_GATE_XCLR] = bus.xclr_i;
  assign w_in[c_GATE_INCK] = bus.inck_en_i;
  assign w_in[c_GATE_V33]  = bus.reg_3v3_en_i;
  assign w_in[c_GATE_V18]  = bus.reg_1v8_en_i;
  assign w_in[c_GATE_V12]  = bus.reg_1v2_en_i;

  assign w_in_step  = is_step_state(r_state);
  // Hold the timer at zero outside the removal steps and restart it on the
  // terminal cycle so every step begins from a fresh count.
  assign w_step_clr = !w_in_step || w_step_tc;

  cam_pwr_step_timer #(
    .STEP_DELAY (STEP_DELAY)
  ) u_step_timer (
    .ctrl_clk_i (ctrl_clk_i),
    .ctrl_rst_i (ctrl_rst_i),
    .clr_i      (w_step_clr),
    .en_i       (w_in_step),
    .tc_o       (w_step_tc)
  );

  // Request is registered first, so the FSM reacts one cycle after the
  // request is sampled and all outputs follow the state one cycle later.
  always_ff @(posedge ctrl_clk_i) begin
    if (ctrl_rst_i) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_out     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef CAM_PWROFF_STATUS_EN
      r_state_o <= c_ST_IDLE;
`endif
    end else begin
      r_req     <= bus.pwrdn_req_i;
      r_out     <= w_in & pwroff_mask(r_state);
      r_busy    <= w_in_step;
      r_done    <= (r_state == ST_DONE);
`ifdef CAM_PWROFF_STATUS_EN
      r_state_o <= r_state;
`endif
      case (r_state)
        ST_IDLE:     if (r_req)     r_state <= ST_XCLR_OFF;
        ST_XCLR_OFF: if (w_step_tc) r_state <= ST_INCK_OFF;
        ST_INCK_OFF: if (w_step_tc) r_state <= ST_V33_OFF;
        ST_V33_OFF:  if (w_step_tc) r_state <= ST_V18_OFF;
        ST_V18_OFF:  if (w_step_tc) r_state <= ST_V12_OFF;
        ST_V12_OFF:  if (w_step_tc) r_state <= ST_DONE;
        // Leave DONE only once completion is already visible on
        // pwrdn_done_o, so a request released early still yields a
        // completion report before pass-through resumes.
        ST_DONE:     if (!r_req && r_done) r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.xclr_o       = r_out[c_GATE_XCLR];
  assign bus.inck_en_o    = r_out[c_GATE_INCK];
  assign bus.reg_3v3_en_o = r_out[c_GATE_V33];
  assign bus.reg_1v8_en_o = r_out[c_GATE_V18];
  assign bus.reg_1v2_en_o = r_out[c_GATE_V12];
  assign bus.busy_o       = r_busy;
  assign bus.pwrdn_done_o = r_done;
`ifdef CAM_PWROFF_STATUS_EN
  assign bus.state_o      = r_state_o;
`endif

endmodule
`default_nettype wire

// File: tb/tb_camera_poweroff_sequence_sm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_camera_poweroff_sequence_sm
//  Purpose  : Directed self-checking bench for camera_poweroff_sequence_sm.
//             Instance A uses STEP_DELAY=4, instance B uses STEP_DELAY=0.
//  Macros   : CAM_PWROFF_STATUS_EN - also checks state_o on instance A
//  Revision : 1.0 - initial release
// ============================================================================
module tb_camera_poweroff_sequence_sm;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  camera_poweroff_sequence_sm_if if_a ();
  camera_poweroff_sequence_sm_if if_b ();

  camera_poweroff_sequence_sm #(.STEP_DELAY(32'd4)) u_dut_a (
    .ctrl_clk_i (clk),
    .ctrl_rst_i (rst_a),
    .bus        (if_a)
  );

  camera_poweroff_sequence_sm #(.STEP_DELAY(32'd0)) u_dut_b (
    .ctrl_clk_i (clk),
    .ctrl_rst_i (rst_b),
    .bus        (if_b)
  );

  // Observed outputs as {1V2, 1V8, 3V3, INCK, XCLR}.
  logic [4:0] obs_a;
  logic [4:0] obs_b;
  assign obs_a = {if_a.reg_1v2_en_o, if_a.reg_1v8_en_o, if_a.reg_3v3_en_o, if_a.inck_en_o, if_a.xclr_o};
  assign obs_b = {if_b.reg_1v2_en_o, if_b.reg_1v8_en_o, if_b.reg_3v3_en_o, if_b.inck_en_o, if_b.xclr_o};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in_a(input logic [4:0] v);
    if_a.reg_1v2_en_i = v[4];
    if_a.reg_1v8_en_i = v[3];
    if_a.reg_3v3_en_i = v[2];
    if_a.inck_en_i    = v[1];
    if_a.xclr_i       = v[0];
  endtask

  task automatic set_in_b(input logic [4:0] v);
    if_b.reg_1v2_en_i = v[4];
    if_b.reg_1v8_en_i = v[3];
    if_b.reg_3v3_en_i = v[2];
    if_b.inck_en_i    = v[1];
    if_b.xclr_i       = v[0];
  endtask

`ifdef CAM_PWROFF_STATUS_EN
  // Expected state_o of instance A after edge k of the STEP_DELAY=4 run
  // (request at edge 0, released at edge 8).
  function automatic logic [31:0] exp_state_a(input int k);
    if (k <= 1)  return 32'd0;
    if (k <= 5)  return 32'd1;
    if (k <= 9)  return 32'd2;
    if (k <= 13) return 32'd3;
    if (k <= 17) return 32'd4;
    if (k <= 21) return 32'd5;
    if (k <= 23) return 32'd6;
    return 32'd0;
  endfunction
`endif

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.pwrdn_req_i = 1'b0;
    if_b.pwrdn_req_i = 1'b0;
    set_in_a(5'h1f);
    set_in_b(5'h1f);

    // Reset state
    tick;
    tick;
    check_eq("rst.a.vec",  {27'd0, obs_a}, 32'h0);
    check_eq("rst.a.busy", {31'd0, if_a.busy_o}, 32'd0);
    check_eq("rst.a.done", {31'd0, if_a.pwrdn_done_o}, 32'd0);
    check_eq("rst.b.vec",  {27'd0, obs_b}, 32'h0);
`ifdef CAM_PWROFF_STATUS_EN
    check_eq("rst.a.state", {29'd0, if_a.state_o}, 32'd0);
`endif

    // Idle pass-through with one-cycle latency
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick;
    check_eq("idle.a.vec",  {27'd0, obs_a}, 32'h1f);
    check_eq("idle.a.busy", {31'd0, if_a.busy_o}, 32'd0);
    check_eq("idle.a.done", {31'd0, if_a.pwrdn_done_o}, 32'd0);
    check_eq("idle.b.vec",  {27'd0, obs_b}, 32'h1f);
    set_in_a(5'b01010);
    tick;
    check_eq("idle.a.pat0a", {27'd0, obs_a}, 32'h0a);
    set_in_a(5'b10101);
    tick;
    check_eq("idle.a.pat15", {27'd0, obs_a}, 32'h15);
    set_in_a(5'h1f);
    tick;
    check_eq("idle.a.pat1f", {27'd0, obs_a}, 32'h1f);

    // STEP_DELAY=4 sequence, request at edge 0, dropped at edge 8
    if_a.pwrdn_req_i = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      tick;
      if (k >= 1) begin
        check_eq($sformatf("seq.a.vec@%0d", k), {27'd0, obs_a},
                 (k >= 24) ? 32'h1f :
                 {27'd0, (k < 18), (k < 14), (k < 10), (k < 6), (k < 2)});
        check_eq($sformatf("seq.a.busy@%0d", k), {31'd0, if_a.busy_o},
                 {31'd0, (k >= 2) && (k <= 21)});
        check_eq($sformatf("seq.a.done@%0d", k), {31'd0, if_a.pwrdn_done_o},
                 {31'd0, (k >= 22) && (k <= 23)});
`ifdef CAM_PWROFF_STATUS_EN
        check_eq($sformatf("seq.a.state@%0d", k), {29'd0, if_a.state_o}, exp_state_a(k));
`endif
      end
      if (k == 7) if_a.pwrdn_req_i = 1'b0;
    end

    // Reset asserted mid-sequence (sampled at edge 13)
    if_a.pwrdn_req_i = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      tick;
      if (k == 12) begin
        check_eq("rmid.a.pre_vec",  {27'd0, obs_a}, 32'h18);
        check_eq("rmid.a.pre_busy", {31'd0, if_a.busy_o}, 32'd1);
        rst_a = 1'b1;
        if_a.pwrdn_req_i = 1'b0;
      end
    end
    check_eq("rmid.a.vec",  {27'd0, obs_a}, 32'h0);
    check_eq("rmid.a.busy", {31'd0, if_a.busy_o}, 32'd0);
    check_eq("rmid.a.done", {31'd0, if_a.pwrdn_done_o}, 32'd0);
`ifdef CAM_PWROFF_STATUS_EN
    check_eq("rmid.a.state", {29'd0, if_a.state_o}, 32'd0);
`endif
    rst_a = 1'b0;
    tick;
    check_eq("rmid.a.post_vec", {27'd0, obs_a}, 32'h1f);
    tick;
    tick;
    check_eq("rmid.a.idle_vec",  {27'd0, obs_a}, 32'h1f);
    check_eq("rmid.a.idle_busy", {31'd0, if_a.busy_o}, 32'd0);

    // STEP_DELAY=0 behaves as 1: outputs fall on edges 2..6, done at 7
    if_b.pwrdn_req_i = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick;
      if (k >= 1) begin
        check_eq($sformatf("d0.b.vec@%0d", k), {27'd0, obs_b},
                 {27'd0, (k < 6), (k < 5), (k < 4), (k < 3), (k < 2)});
        check_eq($sformatf("d0.b.busy@%0d", k), {31'd0, if_b.busy_o},
                 {31'd0, (k >= 2) && (k <= 6)});
        check_eq($sformatf("d0.b.done@%0d", k), {31'd0, if_b.pwrdn_done_o},
                 {31'd0, (k >= 7)});
      end
    end
    // Release from a held DONE: outputs back two edges after the low sample
    if_b.pwrdn_req_i = 1'b0;
    tick;
    check_eq("d0.b.hold_done", {31'd0, if_b.pwrdn_done_o}, 32'd1);
    tick;
    tick;
    check_eq("d0.b.rel_vec",  {27'd0, obs_b}, 32'h1f);
    check_eq("d0.b.rel_done", {31'd0, if_b.pwrdn_done_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
